// File: rtl/reuleaux_seq.sv
// Reuleaux triangle sequencer: derives the three arc centres from a figure centre and
// diameter, then starts the three circle-segment engines in turn and muxes their pixels.
module reuleaux_seq #(
    parameter int K_FRAC  = 16,
    parameter int K_SQ3_6 = 18919
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 done,
    input  logic [7:0]           centre_x,
    input  logic [6:0]           centre_y,
    input  logic [7:0]           diameter,
    output logic signed [9:0]    seg_cx,
    output logic signed [8:0]    seg_cy,
    output logic signed [8:0]    seg_radius,
    output logic [2:0]           seg_start,
    input  logic [2:0]           seg_done,
    input  logic [2:0][7:0]      seg_x,
    input  logic [2:0][6:0]      seg_y,
    input  logic [2:0]           seg_plot,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic                 vga_plot
);

    typedef enum logic [3:0] {
        IDLE, CALC, RUN1, REL1, RUN2, REL2, RUN3, REL3, FIN
    } state_t;

    localparam logic [24:0] C_K1  = 25'(K_SQ3_6);
    localparam logic [24:0] C_K2  = 25'(2 * K_SQ3_6);
    localparam logic [24:0] C_RND = 25'(1) << (K_FRAC - 1);

    state_t      r_state;
    logic [7:0]  r_cx;
    logic [6:0]  r_cy;
    logic [7:0]  r_d;
    logic [9:0]  r_s2x;
    logic [9:0]  r_s3x;
    logic [8:0]  r_s1y;
    logic [8:0]  r_s3y;

    logic [24:0] w_p1;
    logic [24:0] w_p2;
    logic [7:0]  w_h;
    logic [7:0]  w_h2;
    logic [7:0]  w_r;
    logic [9:0]  w_cx;
    logic [8:0]  w_cy;
    logic [9:0]  w_s1x;
    logic [9:0]  w_s2x;
    logic [8:0]  w_s1y;
    logic [8:0]  w_s3y;

    // h and h2 are rounded independently, so h2 may differ from 2*h by one.
    assign w_p1  = 25'(r_d) * C_K1 + C_RND;
    assign w_p2  = 25'(r_d) * C_K2 + C_RND;
    assign w_h   = 8'(w_p1 >> K_FRAC);
    assign w_h2  = 8'(w_p2 >> K_FRAC);
    assign w_r   = {1'b0, r_d[7:1]};
    assign w_cx  = {2'b00, r_cx};
    assign w_cy  = {2'b00, r_cy};
    assign w_s1x = w_cx + {2'b00, w_r};
    assign w_s2x = w_cx - {2'b00, w_r};
    assign w_s1y = w_cy + {1'b0, w_h};
    assign w_s3y = w_cy - {1'b0, w_h2};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            done       <= 1'b0;
            seg_start  <= '0;
            seg_cx     <= '0;
            seg_cy     <= '0;
            seg_radius <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_d        <= '0;
            r_s2x      <= '0;
            r_s3x      <= '0;
            r_s1y      <= '0;
            r_s3y      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done      <= 1'b0;
                    seg_start <= '0;
                    if (start) begin
                        r_cx    <= centre_x;
                        r_cy    <= centre_y;
                        r_d     <= diameter;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_s2x      <= w_s2x;
                    r_s3x      <= w_cx;
                    r_s1y      <= w_s1y;
                    r_s3y      <= w_s3y;
                    seg_radius <= {1'b0, r_d};
                    seg_cx     <= w_s1x;
                    seg_cy     <= w_s1y;
                    seg_start  <= 3'b001;
                    r_state    <= RUN1;
                end
                RUN1: begin
                    if (seg_done[0]) begin
                        seg_start <= '0;
                        r_state   <= REL1;
                    end
                end
                REL1: begin
                    seg_cx    <= r_s2x;
                    seg_cy    <= r_s1y;
                    seg_start <= 3'b010;
                    r_state   <= RUN2;
                end
                RUN2: begin
                    if (seg_done[1]) begin
                        seg_start <= '0;
                        r_state   <= REL2;
                    end
                end
                REL2: begin
                    seg_cx    <= r_s3x;
                    seg_cy    <= r_s3y;
                    seg_start <= 3'b100;
                    r_state   <= RUN3;
                end
                RUN3: begin
                    if (seg_done[2]) begin
                        seg_start <= '0;
                        r_state   <= REL3;
                    end
                end
                REL3: begin
                    done    <= 1'b1;
                    r_state <= FIN;
                end
                FIN: begin
                    if (!start) begin
                        done    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pixel strobe is gated by state so a misbehaving idle engine never reaches the bus.
    always_comb begin
        vga_x    = '0;
        vga_y    = '0;
        vga_plot = 1'b0;
        case (r_state)
            RUN1: begin
                vga_x    = seg_x[0];
                vga_y    = seg_y[0];
                vga_plot = seg_plot[0] & ~seg_done[0];
            end
            RUN2: begin
                vga_x    = seg_x[1];
                vga_y    = seg_y[1];
                vga_plot = seg_plot[1] & ~seg_done[1];
            end
            RUN3: begin
                vga_x    = seg_x[2];
                vga_y    = seg_y[2];
                vga_plot = seg_plot[2] & ~seg_done[2];
            end
            default: ;
        endcase
    end

endmodule
